ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, 32 iterations per operation.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-004 start  input  1  request new operation from EX stage (decoded from ID/EX ALUCtrl).
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only when start accepted.
REQ-006 a  input  32  operand rs / dividend.
REQ-007 b  input  32  operand rt / divisor.
REQ-008 cancel  input  1  squash in-flight operation (pipeline flush).
REQ-009 mthi  input  1  write wdata to HI.
REQ-010 mtlo  input  1  write wdata to LO.
REQ-011 wdata  input  32  data for mthi/mtlo.
REQ-012 busy  output  1  operation in progress; pipeline stalls on MFHI/MFLO/start while high.
REQ-013 done  output  1  one-cycle pulse: HI/LO just updated with a result.
REQ-014 hi  output  32  HI register.
REQ-015 lo  output  32  LO register.

Function
REQ-016 States: IDLE, CALC, DONE; 5-bit iteration counter.
REQ-017 start accepted only in IDLE or DONE, and only when cancel=0; start in CALC ignored.
REQ-018 On acceptance edge E0: latch op, a, b (sign-magnitude converted for MULT/DIV), counter=0, -> CALC.
REQ-019 Later changes on a, b, op have no effect on an accepted operation.
REQ-020 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, counter +1.
REQ-021 Edge E32 (counter==31 in CALC): write HI/LO, -> DONE; busy=1 exactly during cycles after E0 through E32.
REQ-022 done=1 only in DONE (one cycle after E32); DONE -> IDLE unless new start accepted (-> CALC).
REQ-023 MULTU: {hi,lo} = a*b unsigned, 64-bit.
REQ-024 MULT: magnitude product, two's-complement negated if a[31]^b[31].
REQ-025 DIVU: lo = a/b, hi = a%b, unsigned.
REQ-026 DIV: quotient negated if a[31]^b[31]; remainder takes sign of a; 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-027 b==0 on DIV/DIVU: still 32 cycles; result forced lo=0xFFFFFFFF, hi=latched a.
REQ-028 cancel=1 in CALC: -> IDLE next edge, HI/LO unchanged, no done pulse.
REQ-029 cancel=1 in IDLE/DONE: no state effect; blocks start that cycle.
REQ-030 mthi/mtlo honoured only when busy=0; ignored while busy.
REQ-031 mthi/mtlo and accepted start in same cycle: move written at that edge; operation result overwrites at E32.
REQ-032 Result write at E32 takes priority over nothing else; mthi/mtlo at E32 ignored (busy=1).

Reset
REQ-033 reset=0 asynchronously forces state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, latched operands=0.
REQ-034 reset during CALC aborts operation; no done pulse after release.
REQ-035 First start accepted on first rising edge with reset=1.

Verification
REQ-036 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 32 cycles, done pulse, hi=0xFFFFFFFE lo=0x00000001.
REQ-037 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-038 DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=100; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-039 mthi 0x1234 in idle, then MULTU start, cancel at cycle 10 -> busy drops, no done, hi=0x1234 lo=0.
REQ-040 reset asserted at cycle 15 of DIVU -> hi=lo=0, busy=0 immediately; start during busy and mtlo during busy ignored; back-to-back start in DONE cycle accepted.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> multiply/divide unit bundle: request, HI/LO moves, status and HI/LO readback.
// The EX stage is the master; the muldiv unit is the slave.
interface ex_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, cancel, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 32 CALC cycles after the start edge, then a one-cycle done pulse.
// No backpressure: start is only taken in IDLE/DONE; the pipeline stalls on busy.
module ex_muldiv (
  input  logic      clk,
  input  logic      reset,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        div_q;
  logic        neg_q;
  logic        rneg_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] p_q;
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic        finish;
  logic        busy;
  logic        is_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] p_next;
  logic [63:0] mul_res;
  logic [31:0] q_res, r_res;
  logic [63:0] res;

  assign busy      = (state_q == CALC);
  assign accept    = bus.start && !bus.cancel && (state_q != CALC);
  assign finish    = busy && !bus.cancel && (cnt_q == 5'd31);
  assign is_signed = ~bus.op[0];
  assign a_mag     = (is_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign b_mag     = (is_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  // p_q holds {partial product, multiplier} or {remainder, quotient/dividend}
  assign mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next  = {mul_sum, p_q[31:1]};
  assign div_shift = {p_q[63:32], p_q[31]};
  assign div_trial = div_shift - {1'b0, b_q};
  assign div_next  = div_trial[32] ? {div_shift[31:0], p_q[30:0], 1'b0}
                                   : {div_trial[31:0], p_q[30:0], 1'b1};
  assign p_next    = div_q ? div_next : mul_next;

  assign mul_res   = neg_q  ? (64'd0 - p_next) : p_next;
  assign q_res     = neg_q  ? (32'd0 - p_next[31:0])  : p_next[31:0];
  assign r_res     = rneg_q ? (32'd0 - p_next[63:32]) : p_next[63:32];

  always_comb begin
    res = mul_res;
    if (div_q) begin
      // Divide by zero still runs all iterations, then reports a fixed pattern
      if (b_q == 32'd0) res = {a_q, 32'hFFFF_FFFF};
      else              res = {r_res, q_res};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? CALC : IDLE;
      CALC: begin
        if (bus.cancel)           state_d = IDLE;
        else if (cnt_q == 5'd31)  state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 5'd0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      p_q    <= 64'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      if (accept) begin
        div_q  <= bus.op[1];
        neg_q  <= is_signed && (bus.a[31] ^ bus.b[31]);
        rneg_q <= is_signed && bus.a[31];
        a_q    <= bus.a;
        b_q    <= b_mag;
        p_q    <= {32'd0, a_mag};
        cnt_q  <= 5'd0;
      end else if (busy) begin
        p_q   <= p_next;
        cnt_q <= cnt_q + 5'd1;
      end

      if (finish) begin
        hi_q <= res[63:32];
        lo_q <= res[31:0];
      end else if (!busy) begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv; inputs driven and outputs sampled on the falling edge.
module tb_ex_muldiv;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  ex_muldiv_if bus();

  ex_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the unit idle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 32'h0BAD_0BAD; bus.b = 32'h1; bus.op = ~op;
    wait_idle(n);
    check({tag, "_cycles"}, 64'(n), 64'd32);
    check({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, elo});
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int n;
    int done_seen;
    n_vec = 0; n_bad = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
    bus.cancel = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);

    // start presented together with reset release: taken on the first edge out of reset
    reset = 1'b1;
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
    run_op("divu_rem",  2'b11, 32'd100,       32'd7,        32'd2,         32'd14);
    run_op("multu_shf", 2'b01, 32'h1234_5678, 32'h10,       32'd1,         32'h2345_6780);
    run_op("mult_pp",   2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,        32'd6);

    // move and start in the same cycle: move lands first, result overwrites later
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    bus.mthi = 1'b1; bus.wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0;
    check("mv_start_hi", {32'd0, bus.hi}, 64'h0000_ABCD);
    wait_idle(n);
    check("mv_start_res_hi", {32'd0, bus.hi}, 64'd0);
    check("mv_start_res_lo", {32'd0, bus.lo}, 64'd6);
    @(negedge clk);

    // cancel in idle blocks a start
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b01;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("idle_cancel_busy", {63'd0, bus.busy}, 64'd0);

    // mthi in idle, then cancelled MULTU
    bus.mtlo = 1'b1; bus.wdata = 32'd0;
    @(negedge clk);
    bus.mtlo = 1'b0; bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    check("cxl_busy_on", {63'd0, bus.busy}, 64'd1);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cxl_busy_off", {63'd0, bus.busy}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check("cxl_no_done", 64'(done_seen), 64'd0);
    check("cxl_hi", {32'd0, bus.hi}, 64'h0000_1234);
    check("cxl_lo", {32'd0, bus.lo}, 64'd0);

    // start and mtlo while busy are ignored
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd50; bus.b = 32'd5;
    bus.mtlo = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.mtlo = 1'b0;
    check("busy_mtlo_lo", {32'd0, bus.lo}, 64'd0);
    wait_idle(n);
    check("busy_ign_done", {63'd0, bus.done}, 64'd1);
    check("busy_ign_hi", {32'd0, bus.hi}, 64'd0);
    check("busy_ign_lo", {32'd0, bus.lo}, 64'd12);

    // back-to-back start issued in the DONE cycle
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    check("b2b_done", {63'd0, bus.done}, 64'd0);
    wait_idle(n);
    check("b2b_cycles", 64'(n), 64'd32);
    check("b2b_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
    check("b2b_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFA);
    @(negedge clk);

    // reset in the middle of a DIVU
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_calc_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_calc_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_calc_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) done_seen++;
      @(negedge clk);
    end
    check("rst_calc_quiet", 64'(done_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
